// File: rtl/proc_rf_mem_hs.sv
// Register-file processor (ADDI/STORE/LOAD/NOP) with valid/ready instruction input and
// request/response memory port. Optional macro PROC_RF_LOAD_FWD_EN: same-cycle LOAD response.
module proc_rf_mem_hs #(
   parameter int DW   = 8,
   parameter int NREG = 6,
   parameter int IW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [IW-1:0] operand1,
   input  logic [IW-1:0] operand2,
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic          mem_req_we,
   output logic [DW-1:0] mem_req_addr,
   output logic [DW-1:0] mem_req_wdata,
   input  logic          mem_resp_valid,
   input  logic [DW-1:0] mem_resp_data,
   output logic          busy,
   output logic [1:0]    state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // request fields stay stable while valid is high and ready is low. The response has no ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0]  OP_ADDI  = 2'd0;
   localparam logic [1:0]  OP_STORE = 2'd1;
   localparam logic [1:0]  OP_LOAD  = 2'd2;
   localparam logic [IW:0] NREG_L   = (IW+1)'(NREG);

   state_t        state_q, state_d;
   logic [DW-1:0] rf_q [NREG];
   logic          req_we_q;
   logic [DW-1:0] req_addr_q, req_wdata_q;
   logic [IW-1:0] dest_q;

   logic [DW-1:0] rd1, rd2;
   logic          rf_we;
   logic [IW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          capture;

   // Indices beyond the implemented registers read as zero.
   assign rd1 = ({1'b0, operand1} < NREG_L) ? rf_q[operand1] : '0;
   assign rd2 = ({1'b0, operand2} < NREG_L) ? rf_q[operand2] : '0;

   assign in_ready      = (state_q == S_IDLE);
   assign mem_req_valid = (state_q == S_REQ);
   assign busy          = (state_q != S_IDLE);
   assign mem_req_we    = req_we_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_wdata = req_wdata_q;
   assign state_dbg     = state_q;

   always_comb begin
      state_d  = state_q;
      rf_we    = 1'b0;
      rf_waddr = operand1;
      rf_wdata = rd2 + DW'(1);
      capture  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               case (op)
                  OP_ADDI:  rf_we = 1'b1;
                  OP_STORE,
                  OP_LOAD: begin
                     capture = 1'b1;
                     state_d = S_REQ;
                  end
                  default: ;
               endcase
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               if (req_we_q) begin
                  state_d = S_IDLE;
               end else begin
`ifdef PROC_RF_LOAD_FWD_EN
                  if (mem_resp_valid) begin
                     rf_we    = 1'b1;
                     rf_waddr = dest_q;
                     rf_wdata = mem_resp_data;
                     state_d  = S_IDLE;
                  end else begin
                     state_d = S_RESP;
                  end
`else
                  state_d = S_RESP;
`endif
               end
            end
         end
         S_RESP: begin
            if (mem_resp_valid) begin
               rf_we    = 1'b1;
               rf_waddr = dest_q;
               rf_wdata = mem_resp_data;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         dest_q      <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (rf_we && ({1'b0, rf_waddr} < NREG_L)) rf_q[rf_waddr] <= rf_wdata;
         // Operands are frozen at acceptance; the request ignores later input changes.
         if (capture) begin
            req_we_q    <= (op == OP_STORE);
            req_addr_q  <= (op == OP_STORE) ? rd1 : rd2;
            req_wdata_q <= (op == OP_STORE) ? rd2 : '0;
            dest_q      <= operand1;
         end
      end
   end

endmodule
